// File: rtl/serial_adder_if.sv
// serial_adder_if
// Bundles the request/operand and result/status signals of the bit-serial
// adder so the requester and the adder connect through one port.
//   master : drives start, a, b, c_in; observes sum, c_out, busy, done
//   slave  : the adder side (inputs/outputs mirrored)
// WIDTH must match the WIDTH of the serial_adder it is connected to.
interface serial_adder_if #(
    parameter int WIDTH = 4
) ();
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             busy;
    logic             done;

    modport master (
        output start, a, b, c_in,
        input  sum, c_out, busy, done
    );

    modport slave (
        input  start, a, b, c_in,
        output sum, c_out, busy, done
    );
endinterface

// File: rtl/serial_adder.sv
// serial_adder
// Bit-serial ripple adder: computes {c_out, sum} = a + b + c_in one bit per
// clock, LSB first, with a single full-adder cell and a carry flop.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous, active-high reset (priority over everything)
//   bus  - serial_adder_if.slave:
//            start (in, sampled only when idle), a/b/c_in (in, captured on
//            accepted start), sum/c_out (out, registered, updated only on
//            completion), busy (out), done (out, one-cycle pulse)
// Latency: start accepted at E0, done high after edge E_WIDTH, idle again
// after E_(WIDTH+1); one operation per WIDTH+2 cycles.
module serial_adder #(
    parameter int WIDTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    serial_adder_if.slave bus
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_next_s;

    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] acc_r;
    logic             carry_r;
    logic [CW-1:0]    cnt_r;

    logic [WIDTH-1:0] sum_r;
    logic             c_out_r;
    logic             busy_r;
    logic             done_r;

    logic             sum_bit_s;
    logic             carry_next_s;
    logic [WIDTH-1:0] acc_next_s;
    logic             last_bit_s;

    // Full-adder sum bit.
    function automatic logic xor3(input logic x, input logic y, input logic z);
        return x ^ y ^ z;
    endfunction

    // Full-adder carry: majority of the three inputs.
    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    // Single full-adder cell operating on the current LSBs and carry.
    always_comb begin
        sum_bit_s    = xor3(a_r[0], b_r[0], carry_r);
        carry_next_s = maj3(a_r[0], b_r[0], carry_r);
        // New bit enters at the MSB; after WIDTH shifts bit 0 is the LSB.
        acc_next_s   = {sum_bit_s, acc_r[WIDTH-1:1]};
        last_bit_s   = (cnt_r == CNT_LAST);
    end

    // Next-state logic for the IDLE -> SHIFT -> DONE sequence.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_next_s = ST_SHIFT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (last_bit_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Operand capture, bit-serial datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r     <= '0;
            b_r     <= '0;
            acc_r   <= '0;
            carry_r <= 1'b0;
            cnt_r   <= '0;
            sum_r   <= '0;
            c_out_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    // Operands are only looked at here, so anything driven
                    // on a/b/c_in outside an accepted start cannot leak out.
                    if (bus.start) begin
                        a_r     <= bus.a;
                        b_r     <= bus.b;
                        carry_r <= bus.c_in;
                        acc_r   <= '0;
                        cnt_r   <= '0;
                        busy_r  <= 1'b1;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    carry_r <= carry_next_s;
                    acc_r   <= acc_next_s;
                    a_r     <= {1'b0, a_r[WIDTH-1:1]};
                    b_r     <= {1'b0, b_r[WIDTH-1:1]};
                    cnt_r   <= cnt_r + CNT_ONE;
                    // Results are published only here, so partial sums
                    // never appear on sum/c_out.
                    if (last_bit_s) begin
                        sum_r   <= acc_next_s;
                        c_out_r <= carry_next_s;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                end
                default: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sum   = sum_r;
    assign bus.c_out = c_out_r;
    assign bus.busy  = busy_r;
    assign bus.done  = done_r;

endmodule
